// File: rtl/three_port_ram_ctrl_pkg.sv
// Shared types and helpers for the RAM write-port scheduler.
// The pointer width helper never returns zero, so a 2-requester build still gets a 1-bit pointer.
package three_port_ram_ctrl_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } wr_sched_state_e;

    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_onehot.sv
// Combinational round-robin pick: first set request at or above ptr_i, wrapping around.
// Zero latency; any_gnt_o is low when no request is set.
module rr_arb_onehot
    import three_port_ram_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_gnt_o
);

    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base, input int ofs);
        int s;
        s = int'(base) + ofs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[IDX_W-1:0];
    endfunction

    // Scan starts at the pointer so the last winner drops to lowest priority.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_gnt_o && req_i[rot_idx(ptr_i, k)]) begin
                any_gnt_o                = 1'b1;
                gnt_idx_o                = rot_idx(ptr_i, k);
                gnt_o[rot_idx(ptr_i, k)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/three_port_ram_wr_sched.sv
// Round-robin scheduler for the single RAM write port, with a clear sweep after reset or Clear_SI.
// One registered stage to the RAM; requesters see ReqReady_SO low while a sweep runs or Clear_SI is seen.
module three_port_ram_wr_sched
    import three_port_ram_ctrl_pkg::*;
#(
    parameter int                    NUM_REQ    = 4,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DATA_DEPTH = 1024,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                          Clk_CI,
    input  logic                          Rst_RI,
    input  logic                          Clear_SI,
    output logic                          Busy_SO,
    input  logic [NUM_REQ-1:0]            ReqValid_SI,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr_DI,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData_DI,
    output logic [NUM_REQ-1:0]            ReqReady_SO,
    output logic                          WrEn_SO,
    output logic [ADDR_WIDTH-1:0]         WrAddr_DO,
    output logic [DATA_WIDTH-1:0]         WrData_DO
);

    localparam int                PTR_W    = clog2_min1(NUM_REQ);
    localparam int                CNT_W    = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_REQ - 1);

    wr_sched_state_e         state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]      arb_gnt;
    logic [PTR_W-1:0]        arb_idx;
    logic                    arb_any;
    logic                    grant_ok;

    rr_arb_onehot #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (PTR_W)
    ) u_rr_arb (
        .req_i     (ReqValid_SI),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .any_gnt_o (arb_any)
    );

    // A clear request suppresses the grant in the same cycle so no handshake is accepted then lost.
    assign grant_ok    = (state_q == ARB) && !Clear_SI;
    assign ReqReady_SO = {NUM_REQ{grant_ok}} & arb_gnt;
    assign Busy_SO     = (state_q == CLEAR);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            CLEAR: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q[ADDR_WIDTH-1:0];
                wr_data_d = INIT_VALUE;
                if (Clear_SI) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ARB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ARB: begin
                if (Clear_SI) begin
                    cnt_d   = '0;
                    state_d = CLEAR;
                end else if (arb_any) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ReqAddr_DI[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wr_data_d = ReqData_DI[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    ptr_d     = (arb_idx == PTR_LAST) ? '0 : arb_idx + PTR_W'(1);
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign WrEn_SO   = wr_en_q;
    assign WrAddr_DO = wr_addr_q;
    assign WrData_DO = wr_data_q;

endmodule
